// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the in-order RV32I pipeline. It tracks in-flight writers
// in a shifting scoreboard and drives stall, flush and operand-forwarding selects.
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int RADDR_W    = 5,
  parameter int LOAD_AVAIL = 2,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  input  logic [RADDR_W-1:0] dec_rs1,
  input  logic [RADDR_W-1:0] dec_rs2,
  input  logic               dec_use_rs1,
  input  logic               dec_use_rs2,
  input  logic [RADDR_W-1:0] dec_rd,
  input  logic               dec_wen,
  input  logic               dec_is_load,
  input  logic               redirect,
  output logic               stall,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               issue,
  output logic [SEL_W-1:0]   fwd_a,
  output logic [SEL_W-1:0]   fwd_b,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [DEPTH:1]     v_q, v_d;
  logic [DEPTH:1]     wen_q, wen_d;
  logic [DEPTH:1]     ld_q, ld_d;
  logic [RADDR_W-1:0] rd_q [1:DEPTH];
  logic [RADDR_W-1:0] rd_d [1:DEPTH];
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [SEL_W-1:0]   sel_a, sel_b;
  logic               ld_a, ld_b;
  logic               load_hz;

  // Walk from the oldest slot to the youngest so the youngest match overrides.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v_q[k] && wen_q[k] && (rd_q[k] == dec_rs1) && (dec_rs1 != '0)) begin
        sel_a = SEL_W'(k);
        ld_a  = ld_q[k];
      end
      if (v_q[k] && wen_q[k] && (rd_q[k] == dec_rs2) && (dec_rs2 != '0)) begin
        sel_b = SEL_W'(k);
        ld_b  = ld_q[k];
      end
    end
  end

  // ld_a/ld_b are only ever set alongside a nonzero select.
  assign load_hz = dec_valid &
                   ((dec_use_rs1 & ld_a & (sel_a < SEL_W'(LOAD_AVAIL))) |
                    (dec_use_rs2 & ld_b & (sel_b < SEL_W'(LOAD_AVAIL))));

  always_comb begin
    stall    = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    issue    = 1'b0;
    fwd_a    = dec_use_rs1 ? sel_a : '0;
    fwd_b    = dec_use_rs2 ? sel_b : '0;
    if (rst) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
      fwd_a    = '0;
      fwd_b    = '0;
    end else if (redirect) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (load_hz) begin
      stall    = 1'b1;
      flush_de = 1'b1;
    end else begin
      issue    = dec_valid;
    end
  end

  // A non-issuing cycle drops a bubble into slot 1; the oldest entry falls off.
  always_comb begin
    v_d     = v_q;
    wen_d   = wen_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    v_d[1]   = issue;
    wen_d[1] = dec_wen;
    ld_d[1]  = dec_is_load;
    rd_d[1]  = dec_rd;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]   = v_q[k-1];
      wen_d[k] = wen_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Payload fields are qualified by v, so they need no reset.
  always_ff @(posedge clk) begin
    wen_q <= wen_d;
    ld_q  <= ld_d;
    rd_q  <= rd_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a queue-based model of the pipeline history.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH      = 3;
  localparam int LOAD_AVAIL = 2;
  localparam int CNT_W      = 4;
  localparam int CMAX       = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic       dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0;
  logic       dec_wen = 1'b0, dec_is_load = 1'b0, redirect = 1'b0;
  logic       stall, flush_fd, flush_de, issue;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct { bit v; bit [4:0] rd; bit wen; bit ld; } ent_t;
  ent_t hist[$];
  int   m_scnt, m_fcnt;

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .RADDR_W(5), .LOAD_AVAIL(LOAD_AVAIL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wen(dec_wen),
    .dec_is_load(dec_is_load), .redirect(redirect), .stall(stall), .flush_fd(flush_fd),
    .flush_de(flush_de), .issue(issue), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic w, input logic l, input logic rdr);
    dec_valid = v; dec_rs1 = r1; dec_rs2 = r2; dec_use_rs1 = u1; dec_use_rs2 = u2;
    dec_rd = rd; dec_wen = w; dec_is_load = l; redirect = rdr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Youngest writer of rs in the model history (1 = most recently entered slot).
  function automatic int youngest(input logic [4:0] rs, output bit is_ld);
    is_ld = 1'b0;
    if (rs == 5'd0) return 0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].v && hist[i].wen && hist[i].rd == rs) begin
        is_ld = hist[i].ld;
        return i + 1;
      end
    return 0;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 5, 6, 1, 1, 7, 1, 0, 0);
    @(negedge clk);
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_stall got=%0b exp=0", stall); end
    tests_run++; if (issue !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_issue got=%0b exp=0", issue); end
    tests_run++; if ({flush_fd, flush_de} !== 2'b11) begin tests_failed++; $display("[TB] FAIL rst_flush got=%b exp=11", {flush_fd, flush_de}); end
    tests_run++; if ({fwd_a, fwd_b} !== 4'd0) begin tests_failed++; $display("[TB] FAIL rst_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
    tests_run++; if (stall_cnt !== '0 || flush_cnt !== '0) begin tests_failed++; $display("[TB] FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_forwarding();
    do_reset();
    @(negedge clk); drive(1, 1, 2, 1, 1, 5, 1, 0, 0); #1;
    tests_run++; if (issue !== 1'b1 || stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd_first got issue=%0b stall=%0b exp 1/0", issue, stall); end
    @(negedge clk); drive(1, 5, 1, 1, 1, 6, 1, 0, 0); #1;
    tests_run++; if (fwd_a !== 2'd1 || fwd_b !== 2'd0) begin tests_failed++; $display("[TB] FAIL fwd_slot1 got=%0d/%0d exp=1/0", fwd_a, fwd_b); end
    tests_run++; if (issue !== 1'b1 || stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd_slot1_issue got issue=%0b stall=%0b exp 1/0", issue, stall); end
    @(negedge clk); drive(1, 5, 5, 1, 1, 7, 1, 0, 0); #1;
    tests_run++; if (fwd_a !== 2'd2 || fwd_b !== 2'd2) begin tests_failed++; $display("[TB] FAIL fwd_slot2 got=%0d/%0d exp=2/2", fwd_a, fwd_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); drive(1, 1, 0, 1, 0, 5, 1, 1, 0); #1;
    tests_run++; if (issue !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_load_issue got=%0b exp=1", issue); end
    @(negedge clk); drive(1, 5, 0, 1, 1, 6, 1, 0, 0); #1;
    tests_run++; if (stall !== 1'b1 || flush_de !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_stall got stall=%0b de=%0b exp 1/1", stall, flush_de); end
    tests_run++; if (issue !== 1'b0 || flush_fd !== 1'b0) begin tests_failed++; $display("[TB] FAIL lu_hold got issue=%0b fd=%0b exp 0/0", issue, flush_fd); end
    @(negedge clk); #1;
    tests_run++; if (stall !== 1'b0 || issue !== 1'b1) begin tests_failed++; $display("[TB] FAIL lu_release got stall=%0b issue=%0b exp 0/1", stall, issue); end
    tests_run++; if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin tests_failed++; $display("[TB] FAIL lu_fwd got=%0d/%0d exp=2/0", fwd_a, fwd_b); end
    tests_run++; if (stall_cnt !== 4'd1) begin tests_failed++; $display("[TB] FAIL lu_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk); drive(1, 1, 2, 1, 1, 0, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 1, 1, 3, 1, 0, 0); #1;
    tests_run++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin tests_failed++; $display("[TB] FAIL x0_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
    tests_run++; if (stall !== 1'b0 || issue !== 1'b1) begin tests_failed++; $display("[TB] FAIL x0_issue got stall=%0b issue=%0b exp 0/1", stall, issue); end
  endtask

  task automatic test_redirect_over_load();
    do_reset();
    @(negedge clk); drive(1, 1, 0, 1, 0, 5, 1, 1, 0);
    @(negedge clk); drive(1, 5, 0, 1, 1, 6, 1, 0, 1); #1;
    tests_run++; if (stall !== 1'b0 || issue !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_stall got stall=%0b issue=%0b exp 0/0", stall, issue); end
    tests_run++; if ({flush_fd, flush_de} !== 2'b11) begin tests_failed++; $display("[TB] FAIL rd_flush got=%b exp=11", {flush_fd, flush_de}); end
    @(negedge clk); drive(1, 5, 0, 1, 1, 6, 1, 0, 0); #1;
    tests_run++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL rd_cnt got f=%0d s=%0d exp 1/0", flush_cnt, stall_cnt); end
    tests_run++; if (fwd_a !== 2'd2 || stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_advance got fwd_a=%0d stall=%0b exp 2/0", fwd_a, stall); end
  endtask

  task automatic test_youngest();
    do_reset();
    @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 8, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    @(negedge clk); drive(1, 5, 8, 1, 1, 9, 1, 0, 0); #1;
    tests_run++; if (fwd_a !== 2'd1 || fwd_b !== 2'd2) begin tests_failed++; $display("[TB] FAIL young_fwd got=%0d/%0d exp=1/2", fwd_a, fwd_b); end
    repeat (3) begin @(negedge clk); idle(); end
    @(negedge clk); drive(1, 5, 8, 1, 1, 9, 1, 0, 0); #1;
    tests_run++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin tests_failed++; $display("[TB] FAIL drained_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    @(negedge clk); drive(1, 1, 0, 1, 0, 5, 1, 1, 0);
    @(negedge clk); drive(1, 5, 0, 1, 0, 6, 1, 0, 0); #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL ms_pre got=%0b exp=1", stall); end
    rst = 1'b1; #1;
    tests_run++; if (stall !== 1'b0 || issue !== 1'b0 || fwd_a !== 2'd0) begin tests_failed++; $display("[TB] FAIL ms_drop got stall=%0b issue=%0b fwd_a=%0d exp 0/0/0", stall, issue, fwd_a); end
    @(negedge clk); rst = 1'b0; #1;
    tests_run++; if (stall !== 1'b0 || issue !== 1'b1 || fwd_a !== 2'd0) begin tests_failed++; $display("[TB] FAIL ms_clean got stall=%0b issue=%0b fwd_a=%0d exp 0/1/0", stall, issue, fwd_a); end
    tests_run++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL ms_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (20) begin
      @(negedge clk); drive(1, 1, 0, 1, 0, 5, 1, 1, 0);
      @(negedge clk); drive(1, 5, 0, 1, 0, 6, 1, 0, 0);
      @(negedge clk);
    end
    @(negedge clk); idle(); #1;
    tests_run++; if (stall_cnt !== 4'hF) begin tests_failed++; $display("[TB] FAIL sat_stall got=%0d exp=15", stall_cnt); end
    repeat (20) begin @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1); end
    @(negedge clk); idle(); #1;
    tests_run++; if (flush_cnt !== 4'hF) begin tests_failed++; $display("[TB] FAIL sat_flush got=%0d exp=15", flush_cnt); end
  endtask

  task automatic test_random();
    int  k1, k2, e_fa, e_fb;
    bit  l1, l2, hz, e_stall, e_issue, e_fd, e_de;
    ent_t e;
    do_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) begin e.v = 0; e.rd = 0; e.wen = 0; e.ld = 0; hist.push_back(e); end
    m_scnt = 0; m_fcnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      #1;
      k1 = youngest(dec_rs1, l1);
      k2 = youngest(dec_rs2, l2);
      hz = dec_valid && ((dec_use_rs1 && k1 > 0 && l1 && k1 < LOAD_AVAIL) ||
                         (dec_use_rs2 && k2 > 0 && l2 && k2 < LOAD_AVAIL));
      e_fa = (rst || !dec_use_rs1) ? 0 : k1;
      e_fb = (rst || !dec_use_rs2) ? 0 : k2;
      e_stall = !rst && !redirect && hz;
      e_issue = !rst && !redirect && !hz && dec_valid;
      e_fd = rst || redirect;
      e_de = rst || redirect || hz;
      tests_run++; if (stall !== e_stall || issue !== e_issue) begin tests_failed++; $display("[TB] FAIL rnd_ctrl cyc=%0d got stall=%0b issue=%0b exp %0b/%0b", cyc, stall, issue, e_stall, e_issue); end
      tests_run++; if (flush_fd !== e_fd || flush_de !== e_de) begin tests_failed++; $display("[TB] FAIL rnd_flush cyc=%0d got fd=%0b de=%0b exp %0b/%0b", cyc, flush_fd, flush_de, e_fd, e_de); end
      if (rst || dec_valid) begin
        tests_run++; if (fwd_a !== 2'(e_fa) || fwd_b !== 2'(e_fb)) begin tests_failed++; $display("[TB] FAIL rnd_fwd cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, fwd_a, fwd_b, e_fa, e_fb); end
      end
      tests_run++; if (stall_cnt !== CNT_W'(m_scnt) || flush_cnt !== CNT_W'(m_fcnt)) begin tests_failed++; $display("[TB] FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stall_cnt, flush_cnt, m_scnt, m_fcnt); end
      // Advance the model to what the coming clock edge commits.
      if (rst) begin
        foreach (hist[i]) hist[i].v = 0;
        m_scnt = 0; m_fcnt = 0;
      end else begin
        e.v = e_issue; e.rd = dec_rd; e.wen = dec_wen; e.ld = dec_is_load;
        hist.push_front(e);
        void'(hist.pop_back());
        if (e_stall && m_scnt < CMAX) m_scnt++;
        if (redirect && m_fcnt < CMAX) m_fcnt++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_x0();
    test_redirect_over_load();
    test_youngest();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
